// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing an 8-LED bank between NREQ requesters, with a minimum ownership time in prescaled ticks.
// Optional idle heartbeat on led[7] when LED_BANK_ARB_HEARTBEAT_EN is defined.
module led_bank_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PRESC      = 12000,
  parameter int unsigned HOLD_TICKS = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [7:0]        led
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_presc;
  logic [HW-1:0]  r_hold;
  logic [IW-1:0]  r_last;
  logic           w_tick;
  logic           w_found;
  logic [IW-1:0]  w_winner;
  int unsigned    w_idx;
  logic           w_others;
  logic           w_own_req;
  logic [7:0]     w_idle_led;
  logic [7:0]     w_pats [NREQ];

  // Free-running tick prescaler
  assign w_tick = (r_presc == PW'(PRESC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_pats[i] = pat[8*i +: 8];
    end
  end

  // Search starts just after the last owner, so the last owner is considered last
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (32'(r_last) + k) % NREQ;
      if (!w_found && req[IW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  assign w_others  = |(req & ~gnt);
  assign w_own_req = req[r_last];

`ifdef LED_BANK_ARB_HEARTBEAT_EN
  localparam int unsigned HB_TICKS = 500;

  logic [8:0] r_hb_cnt;
  logic       r_hb;
  logic       w_hb_flip;

  assign w_hb_flip = w_tick && (r_hb_cnt == 9'(HB_TICKS - 1));

  // Heartbeat restarts from zero on every entry to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (w_hb_flip) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
    end else if (w_tick) begin
      r_hb_cnt <= r_hb_cnt + 9'(1);
    end
  end

  assign w_idle_led = {r_hb ^ w_hb_flip, 7'b0};
`else
  assign w_idle_led = 8'h00;
`endif

  // Ownership FSM; r_last doubles as the current owner while in OWN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      led     <= 8'h00;
      r_last  <= IW'(NREQ - 1);
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWN;
            gnt     <= NREQ'(1) << w_winner;
            led     <= w_pats[w_winner];
            r_last  <= w_winner;
            r_hold  <= HW'(HOLD_TICKS);
            busy    <= 1'b1;
          end else begin
            led <= w_idle_led;
          end
        end
        S_OWN: begin
          if (!w_own_req || ((r_hold == '0) && w_others)) begin
            r_state <= S_GAP;
            gnt     <= '0;
            led     <= 8'h00;
            busy    <= 1'b0;
          end else begin
            led <= w_pats[r_last];
            if (w_tick && (r_hold != '0)) begin
              r_hold <= r_hold - HW'(1);
            end
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
          led     <= 8'h00;
        end
        default: begin
          r_state <= S_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          led     <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_led_bank_arbiter;

  localparam int NREQ       = 4;
  localparam int PRESC      = 4;
  localparam int HOLD_TICKS = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] pat;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [7:0]        led;

  int n_tests;
  int n_fail;

  // Model: owner index (-1 = none), pending blanking cycle, hold ticks left
  int         m_owner;
  int         m_last;
  int         m_hold;
  int         m_cyc;
  bit         m_gap;
  logic [7:0] m_led;

  led_bank_arbiter #(
    .NREQ      (NREQ),
    .PRESC     (PRESC),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .pat (pat),
    .gnt (gnt),
    .busy(busy),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_hold  = 0;
    m_cyc   = 0;
    m_gap   = 1'b0;
    m_led   = 8'h00;
  endtask

  function automatic logic [NREQ-1:0] exp_gnt();
    if (m_owner < 0) return '0;
    return NREQ'(1) << m_owner;
  endfunction

  // One clock edge of the specified behaviour, using the inputs sampled at that edge
  task automatic model_step();
    bit tick;
    bit others;
    int w;
    tick = ((m_cyc % PRESC) == PRESC - 1);
    m_cyc++;
    if (m_gap) begin
      m_gap = 1'b0;
      m_led = 8'h00;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hold  = HOLD_TICKS;
        m_led   = pat[8*w +: 8];
      end else begin
        m_led = 8'h00;
      end
    end else begin
      others = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (j != m_owner && req[j]) others = 1'b1;
      end
      if (!req[m_owner] || (m_hold == 0 && others)) begin
        m_owner = -1;
        m_gap   = 1'b1;
        m_led   = 8'h00;
      end else begin
        m_led = pat[8*m_owner +: 8];
        if (tick && m_hold > 0) m_hold--;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(exp_gnt()));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("led", 32'(led), 32'(m_led));
  endtask

  // Mid-cycle asynchronous reset pulse, released on a falling edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [NREQ-1:0] seq_q [$];
  logic [NREQ-1:0] exp_seq [5];
  logic [NREQ-1:0] prev;
  int n;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = '0;
    pat = '0;
    model_reset();
    exp_seq = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};

    repeat (3) @(negedge clk);
    check("init_gnt", 32'(gnt), 32'h0);
    check("init_led", 32'(led), 32'h0);
    rst = 1'b0;
    model_reset();

    // Idle after reset: LEDs stay dark
    repeat (50) cycle();

    // Single requester, then pattern follow
    req = 4'b0001;
    pat[7:0] = 8'hA5;
    cycle();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_led", 32'(led), 32'hA5);
    check("single_busy", 32'(busy), 32'h1);
    pat[7:0] = 8'h3C;
    cycle();
    check("pat_follow", 32'(led), 32'h3C);
    req = '0;
    repeat (3) cycle();

    // Two simultaneous requesters alternate with blanking between owners
    do_reset();
    pat = 32'h33_22_11_00;
    req = 4'b1010;
    cycle();
    check("rr_first", 32'(gnt), 32'b0010);
    seq_q.delete();
    seq_q.push_back(gnt);
    prev = gnt;
    repeat (29) begin
      cycle();
      if (gnt != prev) begin
        seq_q.push_back(gnt);
        prev = gnt;
      end
    end
    check("rr_len", 32'(seq_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq_q.size(); i++) begin
      check($sformatf("rr_seq%0d", i), 32'(seq_q[i]), 32'(exp_seq[i]));
    end

    // Hold enforcement against an early competing request
    do_reset();
    req = 4'b0001;
    cycle();
    req = 4'b0101;
    n = 0;
    while (n < 40 && gnt != 4'b0100) begin
      cycle();
      n++;
    end
    check("hold_cycles", 32'(n), 32'd14);

    // Voluntary release while hold is still pending
    do_reset();
    req = 4'b0001;
    repeat (4) cycle();
    req = 4'b0000;
    cycle();
    check("rel_gnt", 32'(gnt), 32'h0);
    check("rel_busy", 32'(busy), 32'h0);
    check("rel_led", 32'(led), 32'h0);
    cycle();
    check("rel_idle_led", 32'(led), 32'h0);

    // Reset during ownership returns the pointer
    do_reset();
    req = 4'b0100;
    pat = 32'h00_5A_00_00;
    cycle();
    check("own2_gnt", 32'(gnt), 32'b0100);
    do_reset();
    req = 4'b1111;
    cycle();
    check("ptr_reset", 32'(gnt), 32'b0001);

    // Random traffic with sticky requests so holds and pre-emption occur
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 2) == 0) pat = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the board's 8-LED bank between NREQ independent requesters. Each requester presents an 8-bit pattern and a request line.
- Round-robin arbitration, with a minimum ownership time counted in prescaled ticks.
- Sits between the application blocks and the top-level LED pins. The top level maps led[0]..led[7] to LED1..LED8.
- When no requester owns the bank, all LEDs are driven to '0', so no pin is ever left at an uncertain level.

Parameters:
- NREQ, 4: number of requesters (2..8).
- PRESC, 12000: clock cycles per tick (1 ms at 12 MHz); minimum 2.
- HOLD_TICKS, 250: minimum ownership in ticks before another requester may pre-empt; 0 is legal.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- req, input, NREQ: request lines; bit i belongs to requester i.
- pat, input, 8*NREQ: patterns; requester i uses pat[8i+7:8i].
- gnt, output, NREQ: one-hot grant, or all-zero.
- busy, output, 1: high while state is OWN.
- led, output, 8: LED bank drive; bit0 = LED1.

Behaviour:
- Reset is asynchronous, active-high. Its values apply immediately and hold while rst is high:
  - gnt=0, busy=0, led=8'h00
  - state=IDLE
  - tick prescaler=0, hold counter=0
  - last_owner=NREQ-1, so requester 0 has first priority.
- Prescaler:
  - Free-running, counts 0..PRESC-1.
  - tick is high for one clk when the count equals PRESC-1, then the count wraps to 0.
  - The first tick after reset release occurs on cycle PRESC.
- States: IDLE, OWN, GAP.
- IDLE:
  - led=0, gnt=0.
  - If any req bit is set, the winner is the first set bit searching last_owner+1, last_owner+2, ... modulo NREQ.
  - On the next edge: gnt=onehot(winner), led=pat[winner], last_owner=winner, hold=HOLD_TICKS, busy=1, state=OWN.
  - Latency from req asserted (sampled at edge n) to gnt and led valid: 1 cycle (visible after edge n+1).
- OWN:
  - led is registered from pat[owner] every cycle, so a pattern change appears 1 cycle later.
  - On tick, if hold>0, hold is decremented. The counter saturates at 0.
  - Owner's req low → next edge: state=GAP, gnt=0, led=0, busy=0. The hold time is ignored on a voluntary release.
  - hold==0, owner still requesting, any other req set → pre-empt: same transition to GAP.
  - hold==0, no other request → remain in OWN indefinitely.
  - Owner drop and pre-empt condition in the same cycle → single transition to GAP.
- GAP:
  - Exactly 1 cycle with led=0 and gnt=0 (blanking between owners).
  - Unconditionally goes to IDLE.
  - Minimum handover, from release decision to the new owner's gnt: 3 edges (OWN→GAP→IDLE→OWN).
- Round-robin:
  - After owner k, requester k itself is searched last.
  - A single continuous requester re-wins after GAP/IDLE.
- gnt is always one-hot or zero and never changes outside these transitions.
- A req pulse that falls before it is sampled in IDLE is not latched; requests are level-sensitive.
- Reset asserted mid-OWN: the outputs clear immediately and the pointer returns to NREQ-1.

Optional Feature:
- Macro: LED_BANK_ARB_HEARTBEAT_EN.
- Defined:
  - In IDLE only, led[7] toggles every 500 ticks; led[6:0]=0.
  - The heartbeat counter is held at 0 outside IDLE, and led[7] restarts at 0 on each entry to IDLE.
  - GAP still drives all zeros.
- Not defined: IDLE drives led=8'h00. No heartbeat logic is synthesized.

Test Plan:
- Bench parameters: NREQ=4, PRESC=4, HOLD_TICKS=3.
- Reset check: assert rst mid-cycle → gnt=0, busy=0, led=00 immediately. After release with all req=0, led stays 00 for 50 cycles.
- Single request: req=0001, pat0=A5 at edge n → gnt=0001, led=A5, busy=1 after edge n+1. Change pat0 to 3C → led=3C one cycle later.
- Simultaneous requests from reset: req=1010 → req1 granted first.
  - Holding both requests, req3 takes over 1+3 edges after hold reaches 0.
  - Then req1 regains, with a 1-cycle led=00 gap at each handover.
- Hold enforcement: req0 owns; req2 asserted at cycle 1 of ownership → no pre-empt until 3 ticks (12 cycles) have elapsed, then GAP → IDLE → gnt=0100.
- Voluntary release: owner drops req with hold=2 → GAP on the next edge, regardless of hold. No other requests → IDLE, led=00.
- Reset mid-OWN:
  - rst pulsed while gnt=0100 → all outputs clear asynchronously.
  - After release with req=1111 → gnt=0001 (pointer reset confirmed).
  - With LED_BANK_ARB_HEARTBEAT_EN defined, led[7] toggles every 500 ticks while in IDLE.
